mem_port_arbiter: RTL and testbench

Shares one `mainMem` instance between three requesters: the program loader, the data-memory (M-stage) port and the instruction-fetch port. It serialises their transactions through a two-state sequencer and returns read data with a one-cycle done pulse. It generates `fetch_stall` and `data_stall` for the pipeline, so separate instruction and data memories are no longer needed. A fairness counter keeps data traffic from starving fetch, and a watchdog bounds every memory transaction.

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory between loader, data and fetch ports with fair data/fetch arbitration and a watchdog
module mem_port_arbiter #(
  parameter int MAX_DATA_BURST = 4,
  parameter int TIMEOUT        = 64
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        load_req_i,
  input  logic [0:31] load_addr_i,
  input  logic [0:31] load_wdata_i,
  output logic        load_done_o,
  input  logic        data_req_i,
  input  logic        data_wren_i,
  input  logic        data_byte_i,
  input  logic        data_ubyte_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  input  logic [1:0]  data_acc_size_i,
  output logic        data_done_o,
  input  logic        fetch_req_i,
  input  logic [31:0] fetch_addr_i,
  input  logic [1:0]  fetch_acc_size_i,
  output logic        fetch_done_o,
  output logic [31:0] rdata_o,
  output logic        fetch_stall_o,
  output logic        data_stall_o,
  output logic        mem_enable_o,
  output logic        mem_wren_o,
  output logic        mem_byteOnly_o,
  output logic        mem_ubyte_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_in_o,
  output logic [1:0]  mem_acc_size_o,
  input  logic [31:0] mem_data_out_i,
  input  logic        mem_busy_i,
  output logic        err_timeout_o
);
  localparam int BW = $clog2(MAX_DATA_BURST + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_DATA_BURST);
  localparam logic [WW-1:0] WMAX = WW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;
  typedef enum logic [1:0] {O_LOAD, O_DATA, O_FETCH} owner_t;

  state_t        state_q, state_d;
  owner_t        owner_q, owner_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          en_q, en_d, wren_q, wren_d, byte_q, byte_d, ubyte_q, ubyte_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]    size_q, size_d;
  logic          ldone_q, ldone_d, ddone_q, ddone_d, fdone_q, fdone_d, err_q, err_d;
  logic          idle, data_ok, gl, gd, gf, fin, tmo;

  // grant decode in IDLE and transaction-end decode in ACCESS, giving the next state
  always_comb begin
    idle    = state_q == IDLE;
    data_ok = data_req_i & ~(fetch_req_i & (burst_q == BMAX));
    gl      = idle & load_req_i;
    gd      = idle & ~load_req_i & data_ok;
    gf      = idle & ~load_req_i & ~data_ok & fetch_req_i;
    fin     = ~idle & ~mem_busy_i;
    tmo     = ~idle & mem_busy_i & (wd_q == WMAX);
    state_d = idle ? ((gl | gd | gf) ? ACCESS : IDLE) : ((fin | tmo) ? IDLE : ACCESS);
  end

  // sequencer state register
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;

  // next values of the memory-side registers, counters, done pulses and read data
  always_comb begin
    owner_d = owner_q;
    burst_d = burst_q;
    wd_d    = wd_q;
    en_d    = en_q;
    wren_d  = wren_q;
    byte_d  = byte_q;
    ubyte_d = ubyte_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ldone_d = 1'b0;
    ddone_d = 1'b0;
    fdone_d = 1'b0;
    if (gl | gd | gf) begin
      owner_d = gl ? O_LOAD : gd ? O_DATA : O_FETCH;
      en_d    = 1'b1;
      wd_d    = '0;
      addr_d  = gl ? load_addr_i : gd ? data_addr_i : fetch_addr_i;
      wdata_d = gl ? load_wdata_i : gd ? data_wdata_i : '0;
      wren_d  = gl | (gd & data_wren_i);
      size_d  = gl ? 2'b00 : gd ? data_acc_size_i : fetch_acc_size_i;
      byte_d  = gd & data_byte_i;
      ubyte_d = gd & data_ubyte_i;
      burst_d = gd ? (fetch_req_i ? ((burst_q == BMAX) ? burst_q : burst_q + 1'b1) : '0) : gf ? '0 : burst_q;
    end else if (fin | tmo) begin
      ldone_d = owner_q == O_LOAD;
      ddone_d = owner_q == O_DATA;
      fdone_d = owner_q == O_FETCH;
      en_d    = 1'b0;
      wren_d  = fin ? 1'b0 : wren_q;
      rdata_d = tmo ? '0 : (wren_q ? rdata_q : mem_data_out_i);
      err_d   = err_q | tmo;
    end else if (!idle) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // datapath registers
  always_ff @(posedge clock_i or posedge reset_i)
    if (reset_i) begin
      owner_q <= O_LOAD;
      burst_q <= '0;
      wd_q    <= '0;
      en_q    <= 1'b0;
      wren_q  <= 1'b0;
      byte_q  <= 1'b0;
      ubyte_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      ldone_q <= 1'b0;
      ddone_q <= 1'b0;
      fdone_q <= 1'b0;
    end else begin
      owner_q <= owner_d;
      burst_q <= burst_d;
      wd_q    <= wd_d;
      en_q    <= en_d;
      wren_q  <= wren_d;
      byte_q  <= byte_d;
      ubyte_q <= ubyte_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      ldone_q <= ldone_d;
      ddone_q <= ddone_d;
      fdone_q <= fdone_d;
    end

  assign load_done_o    = ldone_q;
  assign data_done_o    = ddone_q;
  assign fetch_done_o   = fdone_q;
  assign rdata_o        = rdata_q;
  assign fetch_stall_o  = fetch_req_i & ~fdone_q;
  assign data_stall_o   = data_req_i & ~ddone_q;
  assign mem_enable_o   = en_q;
  assign mem_wren_o     = wren_q;
  assign mem_byteOnly_o = byte_q;
  assign mem_ubyte_o    = ubyte_q;
  assign mem_addr_o     = addr_q;
  assign mem_data_in_o  = wdata_q;
  assign mem_acc_size_o = size_q;
  assign err_timeout_o  = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario bench for mem_port_arbiter
module tb_mem_port_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic load_req = 0, data_req = 0, data_wren = 0, data_byte = 0, data_ubyte = 0, fetch_req = 0, mem_busy = 0;
  logic [31:0] load_addr = 0, load_wdata = 0, data_addr = 0, data_wdata = 0, fetch_addr = 0;
  logic [1:0] data_acc_size = 0, fetch_acc_size = 0;
  logic load_done, data_done, fetch_done, fetch_stall, data_stall;
  logic mem_enable, mem_wren, mem_byteOnly, mem_ubyte, err_timeout;
  logic [31:0] rdata, mem_addr, mem_data_in, mem_data_out;
  logic [1:0] mem_acc_size;
  logic [31:0] mem [256];
  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DATA_BURST(4), .TIMEOUT(64)) dut (
    .clock_i(clk), .reset_i(rst),
    .load_req_i(load_req), .load_addr_i(load_addr), .load_wdata_i(load_wdata), .load_done_o(load_done),
    .data_req_i(data_req), .data_wren_i(data_wren), .data_byte_i(data_byte), .data_ubyte_i(data_ubyte),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata), .data_acc_size_i(data_acc_size), .data_done_o(data_done),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_acc_size_i(fetch_acc_size), .fetch_done_o(fetch_done),
    .rdata_o(rdata), .fetch_stall_o(fetch_stall), .data_stall_o(data_stall),
    .mem_enable_o(mem_enable), .mem_wren_o(mem_wren), .mem_byteOnly_o(mem_byteOnly), .mem_ubyte_o(mem_ubyte),
    .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in), .mem_acc_size_o(mem_acc_size),
    .mem_data_out_i(mem_data_out), .mem_busy_i(mem_busy), .err_timeout_o(err_timeout)
  );

  // memory stand-in: fixed instruction word at the fetch address, small writable array elsewhere
  assign mem_data_out = (mem_addr == 32'h8002_0000) ? 32'h8FBF_0010 : mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_enable && mem_wren && !mem_busy) mem[mem_addr[9:2]] <= mem_data_in;

  task test_reset;
    #1 rst = 1'b1;
    #1;
    checks++; if ({load_done, data_done, fetch_done} !== 3'b000) begin fails++; $display("FAIL reset_done: got %b want 000", {load_done, data_done, fetch_done}); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err_timeout !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    checks++; if ({mem_enable, mem_wren, mem_byteOnly, mem_ubyte, mem_acc_size} !== 6'b0) begin fails++; $display("FAIL reset_mem_ctl: got %b want 0", {mem_enable, mem_wren, mem_byteOnly, mem_ubyte, mem_acc_size}); end
    checks++; if ({mem_addr, mem_data_in} !== 64'h0) begin fails++; $display("FAIL reset_mem_bus: got %h want 0", {mem_addr, mem_data_in}); end
    @(negedge clk) rst = 1'b0;
  endtask

  task test_fetch;
    @(negedge clk);
    fetch_addr = 32'h8002_0000; fetch_acc_size = 2'b10; fetch_req = 1'b1;
    @(negedge clk);
    checks++; if ({mem_enable, mem_wren, fetch_done, fetch_stall} !== 4'b1001) begin fails++; $display("FAIL fetch_access: got en/wr/done/stall %b want 1001", {mem_enable, mem_wren, fetch_done, fetch_stall}); end
    checks++; if (mem_addr !== 32'h8002_0000) begin fails++; $display("FAIL fetch_addr: got %h want 80020000", mem_addr); end
    @(negedge clk);
    checks++; if (fetch_done !== 1'b1) begin fails++; $display("FAIL fetch_done: got %b want 1", fetch_done); end
    checks++; if (rdata !== 32'h8FBF_0010) begin fails++; $display("FAIL fetch_rdata: got %h want 8fbf0010", rdata); end
    fetch_req = 1'b0;
    @(negedge clk);
    checks++; if ({fetch_done, fetch_stall, mem_enable} !== 3'b000) begin fails++; $display("FAIL fetch_after: got done/stall/en %b want 000", {fetch_done, fetch_stall, mem_enable}); end
  endtask

  task test_store_load;
    @(negedge clk);
    data_addr = 32'h8002_0100; data_wdata = 32'hDEAD_BEEF; data_acc_size = 2'b10; data_wren = 1'b1; data_req = 1'b1;
    @(negedge clk);
    checks++; if ({mem_wren, data_stall, data_done} !== 3'b110) begin fails++; $display("FAIL store_access: got wr/stall/done %b want 110", {mem_wren, data_stall, data_done}); end
    checks++; if (mem_data_in !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_wdata: got %h want deadbeef", mem_data_in); end
    @(negedge clk);
    checks++; if ({data_done, mem_wren} !== 2'b10) begin fails++; $display("FAIL store_done: got done/wr %b want 10", {data_done, mem_wren}); end
    checks++; if (rdata !== 32'h8FBF_0010) begin fails++; $display("FAIL store_rdata_hold: got %h want 8fbf0010", rdata); end
    data_wren = 1'b0;
    @(negedge clk);
    checks++; if ({mem_enable, mem_wren, data_done} !== 3'b100) begin fails++; $display("FAIL read_access: got en/wr/done %b want 100", {mem_enable, mem_wren, data_done}); end
    @(negedge clk);
    checks++; if (data_done !== 1'b1) begin fails++; $display("FAIL read_done: got %b want 1", data_done); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL read_rdata: got %h want deadbeef", rdata); end
    data_req = 1'b0;
  endtask

  task test_fairness;
    int n;
    n = 0;
    @(negedge clk);
    data_addr = 32'h8002_0100; data_wren = 1'b0; data_req = 1'b1; fetch_req = 1'b1;
    for (int c = 0; c < 60 && n < 10; c++) begin
      @(negedge clk);
      if (data_done || fetch_done) begin
        checks++; if (fetch_done !== 1'((n % 5) == 4) || data_done === fetch_done) begin fails++; $display("FAIL fair_grant%0d: got d/f %b%b want %s", n, data_done, fetch_done, ((n % 5) == 4) ? "F" : "D"); end
        n++;
        if (n == 10) begin data_req = 1'b0; fetch_req = 1'b0; end
      end
    end
    checks++; if (n != 10) begin fails++; $display("FAIL fair_count: got %0d grants want 10", n); end
    data_req = 1'b0; fetch_req = 1'b0;
  endtask

  task test_load_priority;
    @(negedge clk);
    load_addr = 32'h8002_0200; load_wdata = 32'h1234_5678; load_req = 1'b1;
    data_addr = 32'h8002_0100; data_acc_size = 2'b10; data_byte = 1'b1; data_ubyte = 1'b1; data_req = 1'b1; fetch_req = 1'b1;
    @(negedge clk);
    checks++; if ({mem_wren, mem_acc_size, mem_byteOnly, mem_ubyte} !== 5'b10000) begin fails++; $display("FAIL load_ctl: got wr/size/b/ub %b want 10000", {mem_wren, mem_acc_size, mem_byteOnly, mem_ubyte}); end
    checks++; if ({mem_addr, mem_data_in} !== {32'h8002_0200, 32'h1234_5678}) begin fails++; $display("FAIL load_bus: got %h want 8002020012345678", {mem_addr, mem_data_in}); end
    @(negedge clk);
    checks++; if ({load_done, data_done, fetch_done} !== 3'b100) begin fails++; $display("FAIL load_done: got l/d/f %b want 100", {load_done, data_done, fetch_done}); end
    load_req = 1'b0;
    @(negedge clk);
    checks++; if ({mem_wren, mem_acc_size, mem_byteOnly, mem_ubyte} !== 5'b01011) begin fails++; $display("FAIL load_next_data: got wr/size/b/ub %b want 01011", {mem_wren, mem_acc_size, mem_byteOnly, mem_ubyte}); end
    checks++; if (mem_addr !== 32'h8002_0100) begin fails++; $display("FAIL load_next_addr: got %h want 80020100", mem_addr); end
    @(negedge clk);
    checks++; if ({data_done, rdata} !== {1'b1, 32'hDEAD_BEEF}) begin fails++; $display("FAIL load_next_done: got %b/%h want 1/deadbeef", data_done, rdata); end
    data_req = 1'b0; fetch_req = 1'b0; data_byte = 1'b0; data_ubyte = 1'b0;
  endtask

  task test_timeout;
    int en;
    bit got;
    en = 0; got = 0;
    @(negedge clk);
    mem_busy = 1'b1; fetch_addr = 32'h8002_0000; fetch_req = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (fetch_done) got = 1'b1;
      else if (mem_enable) en++;
    end
    checks++; if (!got) begin fails++; $display("FAIL tmo_done: got no done want done within 100 cycles"); end
    checks++; if (en != 64) begin fails++; $display("FAIL tmo_cycles: got %0d want 64", en); end
    checks++; if ({err_timeout, rdata} !== {1'b1, 32'h0}) begin fails++; $display("FAIL tmo_flag: got %b/%h want 1/0", err_timeout, rdata); end
    fetch_req = 1'b0; mem_busy = 1'b0;
    @(negedge clk) fetch_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({fetch_done, rdata} !== {1'b1, 32'h8FBF_0010}) begin fails++; $display("FAIL tmo_recover: got %b/%h want 1/8fbf0010", fetch_done, rdata); end
    checks++; if (err_timeout !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b want 1", err_timeout); end
    fetch_req = 1'b0;
  endtask

  task test_reset_mid;
    int pulses;
    pulses = 0;
    @(negedge clk);
    mem_busy = 1'b1; fetch_req = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_enable !== 1'b1) begin fails++; $display("FAIL rstmid_access: got en %b want 1", mem_enable); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({mem_enable, mem_addr, rdata, err_timeout, fetch_done} !== 67'h0) begin fails++; $display("FAIL rstmid_clear: got en %b addr %h rdata %h err %b done %b want all 0", mem_enable, mem_addr, rdata, err_timeout, fetch_done); end
    repeat (3) begin @(negedge clk); if (fetch_done) pulses++; end
    mem_busy = 1'b0; rst = 1'b0;
    @(negedge clk);
    if (fetch_done) pulses++;
    checks++; if (pulses != 0) begin fails++; $display("FAIL rstmid_nodone: got %0d pulses want 0", pulses); end
    @(negedge clk);
    checks++; if ({fetch_done, rdata} !== {1'b1, 32'h8FBF_0010}) begin fails++; $display("FAIL rstmid_fetch: got %b/%h want 1/8fbf0010", fetch_done, rdata); end
    fetch_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store_load;
    test_fairness;
    test_load_priority;
    test_timeout;
    test_reset_mid;
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
